i2c_passthru_multi_bus_recover: RTL
===================================

Name: i2c_passthru_multi_bus_recover

Overview:
- NUM_BUS-channel successor of the single-bus idle/stuck recover block.
- Per channel: tracks idle/active/stuck state of an I2C/SMBus segment.
- One shared recovery sequencer, granted round-robin, clocks out stuck buses (up to RECOV_CLKS SCL pulses, then a STOP) with bounded retries and a sticky failure flag.
- Sits between the passthru core and the pad muxes; the core enables each channel's o_sda/o_scl onto the bus while that channel's o_stuck is high.

Parameters:
NUM_BUS, 2, number of monitored buses (1..8)
F_REF_T_LOW, 38, i_f_ref ticks per recovery phase (t_low/t_high/t_su_sto/t_buf)
F_REF_T_HI, 400, i_f_ref ticks of SCL=SDA=1 while active before idle timeout
F_REF_SLOW_T_STUCK_MAX, 255, i_f_ref_slow ticks of frozen bus with a line low before stuck
RECOV_CLKS, 9, max SCL pulses per recovery attempt (1..15)
RECOV_RETRIES, 3, failed attempts before channel enters FAIL (1..7)
WIDTH_F_REF_T_LOW, 6, ceil(log2(F_REF_T_LOW+1))
WIDTH_F_REF_T_HI, 9, ceil(log2(F_REF_T_HI+1))
WIDTH_F_REF_SLOW_T_STUCK_MAX, 8, ceil(log2(F_REF_SLOW_T_STUCK_MAX+1))

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_f_ref  in  1  timing reference; rising edge = one tick
i_f_ref_slow  in  1  slow timing reference for the stuck timer
i_sda  in  NUM_BUS  sampled SDA per bus
i_scl  in  NUM_BUS  sampled SCL per bus
i_fail_clr  in  NUM_BUS  one-cycle pulse; clears FAIL and the retry count of that channel
o_sda  out  NUM_BUS  recovery SDA drive (1 = release)
o_scl  out  NUM_BUS  recovery SCL drive (1 = release)
o_idle  out  NUM_BUS  bus idle
o_idle_timeout  out  NUM_BUS  one-cycle pulse: idle reached by T_HI timeout
o_stuck  out  NUM_BUS  channel in STUCK, RECOV or FAIL
o_recov_busy  out  NUM_BUS  one-hot; channel currently owns the sequencer
o_fail  out  NUM_BUS  sticky recovery failure

Behaviour:
- Reset (async): all channels IDLE, sequencer R_IDLE, timers loaded with maximum, retries=0, round-robin pointer=0.
- Reset values: o_idle all 1; o_sda, o_scl all 1; all other outputs 0. Outputs decode from state, so reset mid-recovery releases the lines immediately.
- Edges: prev_* registers. start = SCL & SDA fall; stop = SCL & SDA rise. Tick = rising edge of i_f_ref / i_f_ref_slow.
- Per-channel timers:
  - thi: reloads while either line is low; otherwise decrements per tick; saturates at 0.
  - stuck: reloads on any SDA/SCL edge or on SCL=SDA=1; otherwise decrements per slow tick; saturates at 0.
- Channel FSM:
  - IDLE: stuck_tc -> STUCK; else start -> ACTIVE.
  - ACTIVE: stuck_tc -> STUCK; else thi_tc -> TIMEOUT; else stop -> IDLE.
  - TIMEOUT (1 cycle, o_idle=o_idle_timeout=1): stuck_tc -> STUCK; else -> IDLE.
  - STUCK: SCL=SDA=1 -> ACTIVE, retries=0; else on grant -> RECOV.
  - RECOV: sequencer success -> IDLE, retries=0. Failure -> retries+1; FAIL if retries reaches RECOV_RETRIES, else STUCK with stuck timer reloaded.
  - FAIL (o_fail=1): i_fail_clr -> STUCK, retries=0; SCL=SDA=1 for one cycle -> ACTIVE (o_fail stays set until i_fail_clr).
  - Priority: stuck_tc beats start, stop and thi_tc in the same cycle.
- Arbiter: in R_IDLE, grants the lowest-index STUCK channel at or after the pointer; pointer = granted+1 mod NUM_BUS. Grant cycle sets o_recov_busy.
- Sequencer (drives only the granted channel; others read 1/1). Each phase loads the tlow timer with F_REF_T_LOW and ends when it reaches 0.
  - R_LOW: scl=0, sda=1.
  - R_HIGH: scl=1, sda=1. pulse_cnt+1. At phase end: i_sda=1 -> R_STOP0; else pulse_cnt=RECOV_CLKS -> failure; else R_LOW.
  - R_STOP0: scl=0, sda=0.
  - R_STOP1: scl=1, sda=0.
  - R_STOP2: scl=1, sda=1. At end: i_scl & i_sda -> success, else failure.
  - Result pulses for 1 cycle, then R_IDLE.
- Counter widths: pulse_cnt 4 bits, retries 3 bits; no wrap (bounded by parameters).

Optional Feature:
- Macro I2C_PASSTHRU_MULTI_SYNC_EN.
- Defined: i_sda, i_scl and i_f_ref* pass through 2-flop synchronisers (reset to 1/1/0/0) before all logic; every response shifts +2 cycles.
- Undefined: inputs are used directly; the caller guarantees they are synchronous.

Test Plan:
(All: NUM_BUS=2, F_REF_T_LOW=3, F_REF_T_HI=8, F_REF_SLOW_T_STUCK_MAX=4, RECOV_CLKS=9, RECOV_RETRIES=2, i_f_ref and i_f_ref_slow toggling every clock.)
1. Reset -> o_idle=2'b11, o_sda=o_scl=2'b11, o_stuck=0. Start on bus0, then stop -> ACTIVE, then IDLE; no o_idle_timeout.
2. Start on bus1, lines then held 1/1 -> o_idle_timeout[1] pulses once after 8 ticks; o_idle[1]=1.
3. Bus0 SDA held 0, SCL 1, released after the 3rd recovery SCL high -> o_stuck[0]=1 after 4 slow ticks; exactly 3 o_scl[0] low pulses; STOP sequence; channel IDLE, o_fail=0.
4. Both buses SDA stuck low in the same cycle -> bus0 granted first, bus1 after bus0's result; o_recov_busy never two-hot.
5. Bus1 SDA permanently 0 -> two attempts of 9 pulses each; o_fail[1]=1; no further o_scl[1] activity. i_fail_clr[1] -> new attempt starts.
6. i_rst asserted mid-R_LOW -> o_scl=2'b11 in the same cycle, all state reset.

Source files
------------

// File: rtl/i2c_passthru_multi_bus_recover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2c_passthru_multi_bus_recover                             |
// | Description : Per-bus idle/active/stuck tracking for NUM_BUS I2C/SMBus   |
// |               segments. A single shared recovery sequencer is granted    |
// |               round-robin to stuck buses. It clocks out SCL pulses, then |
// |               a STOP, with bounded retries and a sticky failure flag.    |
// | Ports       : i_clk/i_rst      clock, async active-high reset            |
// |               i_f_ref          phase/idle timing reference (rise = tick) |
// |               i_f_ref_slow     stuck-timer reference (rise = tick)       |
// |               i_sda/i_scl      sampled bus lines, one bit per bus        |
// |               i_fail_clr       per-bus pulse clearing FAIL and retries   |
// |               o_sda/o_scl      recovery drive, 1 = release               |
// |               o_idle           bus idle                                  |
// |               o_idle_timeout   pulse when idle is reached by timeout     |
// |               o_stuck          bus in STUCK, RECOV or FAIL               |
// |               o_recov_busy     one-hot owner of the sequencer            |
// |               o_fail           sticky recovery failure                   |
// | Option      : define I2C_PASSTHRU_MULTI_SYNC_EN to add 2-flop input      |
// |               synchronisers (all responses then shift by +2 cycles).     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module i2c_passthru_multi_bus_recover #(
  parameter int NUM_BUS                      = 2,
  parameter int F_REF_T_LOW                  = 38,
  parameter int F_REF_T_HI                   = 400,
  parameter int F_REF_SLOW_T_STUCK_MAX       = 255,
  parameter int RECOV_CLKS                   = 9,
  parameter int RECOV_RETRIES                = 3,
  parameter int WIDTH_F_REF_T_LOW            = 6,
  parameter int WIDTH_F_REF_T_HI             = 9,
  parameter int WIDTH_F_REF_SLOW_T_STUCK_MAX = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_f_ref,
  input  logic               i_f_ref_slow,
  input  logic [NUM_BUS-1:0] i_sda,
  input  logic [NUM_BUS-1:0] i_scl,
  input  logic [NUM_BUS-1:0] i_fail_clr,
  output logic [NUM_BUS-1:0] o_sda,
  output logic [NUM_BUS-1:0] o_scl,
  output logic [NUM_BUS-1:0] o_idle,
  output logic [NUM_BUS-1:0] o_idle_timeout,
  output logic [NUM_BUS-1:0] o_stuck,
  output logic [NUM_BUS-1:0] o_recov_busy,
  output logic [NUM_BUS-1:0] o_fail
);
  localparam int W_OWN = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1;

  typedef enum logic [2:0] {C_IDLE, C_ACTIVE, C_TIMEOUT, C_STUCK, C_RECOV, C_FAIL} chan_state_e;
  typedef enum logic [2:0] {R_IDLE, R_LOW, R_HIGH, R_STOP0, R_STOP1, R_STOP2, R_DONE} seq_state_e;

  logic [NUM_BUS-1:0] sda, scl;
  logic               fref, fslow;

`ifdef I2C_PASSTHRU_MULTI_SYNC_EN
  logic [NUM_BUS-1:0] sda_meta_q, sda_sync_q, scl_meta_q, scl_sync_q;
  logic [1:0]         fref_sync_q, fslow_sync_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sda_meta_q   <= '1;
      sda_sync_q   <= '1;
      scl_meta_q   <= '1;
      scl_sync_q   <= '1;
      fref_sync_q  <= '0;
      fslow_sync_q <= '0;
    end else begin
      sda_meta_q   <= i_sda;
      sda_sync_q   <= sda_meta_q;
      scl_meta_q   <= i_scl;
      scl_sync_q   <= scl_meta_q;
      fref_sync_q  <= {fref_sync_q[0], i_f_ref};
      fslow_sync_q <= {fslow_sync_q[0], i_f_ref_slow};
    end
  end
  assign sda   = sda_sync_q;
  assign scl   = scl_sync_q;
  assign fref  = fref_sync_q[1];
  assign fslow = fslow_sync_q[1];
`else
  assign sda   = i_sda;
  assign scl   = i_scl;
  assign fref  = i_f_ref;
  assign fslow = i_f_ref_slow;
`endif

  // Previous-sample registers for line edges and reference ticks. Lines
  // reset high so a bus that is released at reset shows no edge.
  logic [NUM_BUS-1:0] sda_prev_q, scl_prev_q;
  logic               fref_prev_q, fslow_prev_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sda_prev_q   <= '1;
      scl_prev_q   <= '1;
      fref_prev_q  <= 1'b0;
      fslow_prev_q <= 1'b0;
    end else begin
      sda_prev_q   <= sda;
      scl_prev_q   <= scl;
      fref_prev_q  <= fref;
      fslow_prev_q <= fslow;
    end
  end

  logic tick, tick_slow;
  assign tick      = fref & ~fref_prev_q;
  assign tick_slow = fslow & ~fslow_prev_q;

  // Shared sequencer state
  seq_state_e                   seq_q, seq_d;
  logic [W_OWN-1:0]             owner_q, owner_d, ptr_q, ptr_d, gnt_idx;
  logic [WIDTH_F_REF_T_LOW-1:0] tlow_q, tlow_d;
  logic [3:0]                   pulse_q, pulse_d;
  logic                         ok_q, ok_d, found, seq_scl, seq_sda;
  logic [NUM_BUS-1:0]           stuck_req, grant;

  assign seq_scl = !(seq_q == R_LOW || seq_q == R_STOP0);
  assign seq_sda = !(seq_q == R_STOP0 || seq_q == R_STOP1);

  // Round-robin search starting at the pointer, wrapping around.
  always_comb begin : p_arb
    int idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = ptr_q;
    for (int k = 0; k < NUM_BUS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_BUS) idx = idx - NUM_BUS;
      if (!found && stuck_req[idx[W_OWN-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[W_OWN-1:0];
      end
    end
    grant = '0;
    if (seq_q == R_IDLE && found) grant[gnt_idx] = 1'b1;
  end

  always_comb begin
    seq_d   = seq_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    pulse_d = pulse_q;
    ok_d    = ok_q;
    tlow_d  = tlow_q;
    if (tick && tlow_q != '0) tlow_d = tlow_q - 1'b1;
    case (seq_q)
      R_IDLE: if (found) begin
        owner_d = gnt_idx;
        ptr_d   = (int'(gnt_idx) == NUM_BUS - 1) ? '0 : gnt_idx + 1'b1;
        pulse_d = '0;
        tlow_d  = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
        seq_d   = R_LOW;
      end
      R_LOW: if (tlow_q == '0) begin
        pulse_d = pulse_q + 1'b1;
        tlow_d  = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
        seq_d   = R_HIGH;
      end
      R_HIGH: if (tlow_q == '0) begin
        tlow_d = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
        if (sda[owner_q]) begin
          seq_d = R_STOP0;
        end else if (pulse_q == 4'(RECOV_CLKS)) begin
          ok_d  = 1'b0;
          seq_d = R_DONE;
        end else begin
          seq_d = R_LOW;
        end
      end
      R_STOP0: if (tlow_q == '0) begin
        tlow_d = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
        seq_d  = R_STOP1;
      end
      R_STOP1: if (tlow_q == '0) begin
        tlow_d = WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
        seq_d  = R_STOP2;
      end
      R_STOP2: if (tlow_q == '0) begin
        ok_d  = scl[owner_q] & sda[owner_q];
        seq_d = R_DONE;
      end
      default: seq_d = R_IDLE;  // R_DONE: result is visible for this one cycle
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seq_q   <= R_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      pulse_q <= '0;
      ok_q    <= 1'b0;
      tlow_q  <= WIDTH_F_REF_T_LOW'(F_REF_T_LOW);
    end else begin
      seq_q   <= seq_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      pulse_q <= pulse_d;
      ok_q    <= ok_d;
      tlow_q  <= tlow_d;
    end
  end

  for (genvar b = 0; b < NUM_BUS; b++) begin : g_chan
    chan_state_e                             state_q, state_d;
    logic [WIDTH_F_REF_T_HI-1:0]             thi_q, thi_d;
    logic [WIDTH_F_REF_SLOW_T_STUCK_MAX-1:0] stk_q, stk_d;
    logic [2:0]                              retries_q, retries_d;
    logic                                    fail_q, fail_d, stk_reload;
    logic                                    hi, start, stop, line_edge, mine, done;

    assign hi        = sda[b] & scl[b];
    assign start     = scl[b] & scl_prev_q[b] & sda_prev_q[b] & ~sda[b];
    assign stop      = scl[b] & scl_prev_q[b] & ~sda_prev_q[b] & sda[b];
    assign line_edge = (sda[b] ^ sda_prev_q[b]) | (scl[b] ^ scl_prev_q[b]);
    assign mine      = (seq_q != R_IDLE) && (owner_q == W_OWN'(b));
    assign done      = mine && (seq_q == R_DONE);

    always_comb begin
      state_d    = state_q;
      retries_d  = retries_q;
      fail_d     = fail_q;
      stk_reload = 1'b0;
      if (i_fail_clr[b]) begin
        fail_d = 1'b0;
        if (state_q != C_RECOV) retries_d = '0;
      end
      case (state_q)
        C_IDLE:    if (stk_q == '0) state_d = C_STUCK;
                   else if (start) state_d = C_ACTIVE;
        C_ACTIVE:  if (stk_q == '0) state_d = C_STUCK;
                   else if (thi_q == '0) state_d = C_TIMEOUT;
                   else if (stop) state_d = C_IDLE;
        C_TIMEOUT: state_d = (stk_q == '0) ? C_STUCK : C_IDLE;
        C_STUCK: begin
          if (hi) begin
            state_d   = C_ACTIVE;
            retries_d = '0;
          end else if (grant[b]) begin
            state_d = C_RECOV;
          end
        end
        C_RECOV: if (done) begin
          if (ok_q) begin
            state_d   = C_IDLE;
            retries_d = '0;
          end else begin
            retries_d = retries_q + 1'b1;
            if (retries_q + 3'd1 == 3'(RECOV_RETRIES)) begin
              state_d = C_FAIL;
              fail_d  = 1'b1;
            end else begin
              state_d    = C_STUCK;
              stk_reload = 1'b1;
            end
          end
        end
        default: begin  // C_FAIL
          if (i_fail_clr[b]) state_d = C_STUCK;
          else if (hi) state_d = C_ACTIVE;
        end
      endcase

      if (!hi) thi_d = WIDTH_F_REF_T_HI'(F_REF_T_HI);
      else if (tick && thi_q != '0) thi_d = thi_q - 1'b1;
      else thi_d = thi_q;

      if (line_edge || hi || stk_reload) stk_d = WIDTH_F_REF_SLOW_T_STUCK_MAX'(F_REF_SLOW_T_STUCK_MAX);
      else if (tick_slow && stk_q != '0) stk_d = stk_q - 1'b1;
      else stk_d = stk_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q   <= C_IDLE;
        thi_q     <= WIDTH_F_REF_T_HI'(F_REF_T_HI);
        stk_q     <= WIDTH_F_REF_SLOW_T_STUCK_MAX'(F_REF_SLOW_T_STUCK_MAX);
        retries_q <= '0;
        fail_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        thi_q     <= thi_d;
        stk_q     <= stk_d;
        retries_q <= retries_d;
        fail_q    <= fail_d;
      end
    end

    assign stuck_req[b]      = (state_q == C_STUCK);
    assign o_idle[b]         = (state_q == C_IDLE) || (state_q == C_TIMEOUT);
    assign o_idle_timeout[b] = (state_q == C_TIMEOUT);
    assign o_stuck[b]        = (state_q == C_STUCK) || (state_q == C_RECOV) || (state_q == C_FAIL);
    assign o_fail[b]         = fail_q;
    assign o_recov_busy[b]   = mine;
    assign o_scl[b]          = mine ? seq_scl : 1'b1;
    assign o_sda[b]          = mine ? seq_sda : 1'b1;
  end

endmodule
`default_nettype wire
